// File: rtl/fnn_batch_scheduler.sv
// Batch sequencer: runs num_samples inferences through the FNN core one at a time,
// compares each prediction with its label and accumulates processed/correct counts.
module fnn_batch_scheduler #(
   parameter int unsigned IDX_W   = 10,
   parameter int unsigned PRED_W  = 4,
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned TO_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [IDX_W-1:0]  num_samples,
   output logic              fnn_start,
   output logic [IDX_W-1:0]  sample_idx,
   input  logic              fnn_done,
   input  logic [PRED_W-1:0] fnn_pred,
   output logic              label_rd,
   output logic [IDX_W-1:0]  label_addr,
   input  logic [PRED_W-1:0] label_data,
   output logic              busy,
   output logic              batch_done,
   output logic [IDX_W-1:0]  processed_cnt,
   output logic [IDX_W-1:0]  correct_cnt,
   output logic              timeout_err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, LABEL, WAIT, FINISH} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   num_q, num_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [IDX_W-1:0]   sample_idx_nxt, processed_nxt, correct_nxt;
   logic [PRED_W-1:0]  label_reg, label_nxt;
   logic [TO_W-1:0]    to_cnt, to_nxt;
   logic               timeout_nxt;
   logic               fnn_start_nxt, busy_nxt, batch_done_nxt;
   logic               complete, hit;

   assign label_addr = sample_idx;

   // State and datapath registers; outputs are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         num_q         <= '0;
         idx           <= '0;
         sample_idx    <= '0;
         label_reg     <= '0;
         to_cnt        <= '0;
         processed_cnt <= '0;
         correct_cnt   <= '0;
         timeout_err   <= 1'b0;
         fnn_start     <= 1'b0;
         label_rd      <= 1'b0;
         busy          <= 1'b0;
         batch_done    <= 1'b0;
      end else begin
         state         <= state_nxt;
         num_q         <= num_nxt;
         idx           <= idx_nxt;
         sample_idx    <= sample_idx_nxt;
         label_reg     <= label_nxt;
         to_cnt        <= to_nxt;
         processed_cnt <= processed_nxt;
         correct_cnt   <= correct_nxt;
         timeout_err   <= timeout_nxt;
         fnn_start     <= fnn_start_nxt;
         label_rd      <= fnn_start_nxt;
         busy          <= busy_nxt;
         batch_done    <= batch_done_nxt;
      end
   end

   // Next-state, sample completion and output decode.
   always_comb begin
      state_nxt      = state;
      num_nxt        = num_q;
      idx_nxt        = idx;
      sample_idx_nxt = sample_idx;
      label_nxt      = label_reg;
      to_nxt         = to_cnt;
      processed_nxt  = processed_cnt;
      correct_nxt    = correct_cnt;
      timeout_nxt    = timeout_err;
      complete       = 1'b0;
      hit            = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               num_nxt       = num_samples;
               idx_nxt       = '0;
               processed_nxt = '0;
               correct_nxt   = '0;
               timeout_nxt   = 1'b0;
               state_nxt     = (num_samples == '0) ? FINISH : LAUNCH;
            end
         end
         LAUNCH: begin
            to_nxt    = '0;
            state_nxt = abort ? FINISH : LABEL;
         end
         LABEL: begin
            label_nxt = label_data;
            if (abort) begin
               state_nxt = FINISH;
            end else if (fnn_done) begin
               complete = 1'b1;
               hit      = (fnn_pred == label_data);
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            to_nxt = to_cnt + TO_W'(1);
            if (abort) begin
               state_nxt = FINISH;
            end else if (fnn_done) begin
               complete = 1'b1;
               hit      = (fnn_pred == label_reg);
            end else if (to_cnt == TO_LAST) begin
               complete    = 1'b1;
               timeout_nxt = 1'b1;
            end
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // A timed-out sample counts as processed but never as correct.
      if (complete) begin
         processed_nxt = processed_cnt + IDX_W'(1);
         if (hit) correct_nxt = correct_cnt + IDX_W'(1);
         if (idx == num_q - IDX_W'(1)) begin
            state_nxt = FINISH;
         end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = LAUNCH;
         end
      end

      if (state_nxt == LAUNCH) sample_idx_nxt = idx_nxt;

      fnn_start_nxt  = (state_nxt == LAUNCH);
      busy_nxt       = (state_nxt == LAUNCH) || (state_nxt == LABEL) || (state_nxt == WAIT);
      batch_done_nxt = (state_nxt == FINISH);
   end

endmodule

// File: tb/tb_fnn_batch_scheduler.sv
// Directed bench for fnn_batch_scheduler with a behavioural FNN core, label memory
// and a scoreboard of per-batch results checked at every batch_done.
module tb_fnn_batch_scheduler;

   localparam int unsigned IDX_W   = 10;
   localparam int unsigned PRED_W  = 4;
   localparam int unsigned TIMEOUT = 32;
   localparam int unsigned TO_W    = 8;

   typedef struct packed {
      logic [IDX_W-1:0] proc;
      logic [IDX_W-1:0] corr;
      logic             terr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [IDX_W-1:0]  num_samples = '0;
   logic              fnn_start, label_rd, busy, batch_done, timeout_err;
   logic [IDX_W-1:0]  sample_idx, label_addr, processed_cnt, correct_cnt;
   logic              fnn_done;
   logic [PRED_W-1:0] fnn_pred, label_data;

   logic [PRED_W-1:0] lbl_mem [16];
   logic [PRED_W-1:0] pred_mem[16];
   bit                never   [16];
   int                lat = 20;

   exp_t sb[$];
   int   exp_idx[$];
   int   total = 0, bad = 0;
   int   cyc = 0, bd_count = 0, bd_cyc = 0, last_done_cyc = 0;
   bit   busy_seen = 0;

   logic       m_act;
   int         m_cnt;
   logic [3:0] m_idx;

   fnn_batch_scheduler #(.IDX_W(IDX_W), .PRED_W(PRED_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
      .fnn_start(fnn_start), .sample_idx(sample_idx), .fnn_done(fnn_done), .fnn_pred(fnn_pred),
      .label_rd(label_rd), .label_addr(label_addr), .label_data(label_data),
      .busy(busy), .batch_done(batch_done), .processed_cnt(processed_cnt),
      .correct_cnt(correct_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int p, input int c, input int t);
      exp_t e;
      e.proc = IDX_W'(p);
      e.corr = IDX_W'(c);
      e.terr = 1'(t);
      return e;
   endfunction

   // Label memory: data valid one cycle after label_rd.
   always @(posedge clk) if (label_rd) label_data <= lbl_mem[label_addr[3:0]];

   // FNN core model: one-cycle done pulse lat cycles after fnn_start, unless muted.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         fnn_done <= 1'b0;
         fnn_pred <= '0;
         m_act    <= 1'b0;
         m_cnt    <= 0;
         m_idx    <= '0;
      end else begin
         fnn_done <= 1'b0;
         if (fnn_start) begin
            m_cnt <= lat;
            m_idx <= sample_idx[3:0];
            m_act <= !never[sample_idx[3:0]];
         end else if (m_act) begin
            if (m_cnt <= 1) begin
               fnn_done <= 1'b1;
               fnn_pred <= pred_mem[m_idx];
               m_act    <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // Monitor: launch order and per-batch results against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      int   ei;
      cyc++;
      if (rst) begin
         if (busy) busy_seen = 1;
         if (fnn_done) last_done_cyc = cyc;
         if (fnn_start) begin
            chk("fnn_start_expected", 32'(exp_idx.size() > 0), 1);
            if (exp_idx.size() > 0) begin
               ei = exp_idx.pop_front();
               chk("sample_idx", 32'(sample_idx), ei);
               chk("label_addr", 32'(label_addr), ei);
            end
         end
         if (batch_done) begin
            bd_count++;
            bd_cyc = cyc;
            chk("batch_done_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("processed_cnt", 32'(processed_cnt), 32'(e.proc));
               chk("correct_cnt", 32'(correct_cnt), 32'(e.corr));
               chk("timeout_err", 32'(timeout_err), 32'(e.terr));
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic launch(input int n);
      num_samples = IDX_W'(n);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("launch_fnn_start", 32'(fnn_start), 32'(n != 0));
      chk("launch_busy", 32'(busy), 32'(n != 0));
      chk("launch_batch_done", 32'(batch_done), 32'(n == 0));
   endtask

   task automatic wait_bd(input string tag, input int budget);
      int b0 = bd_count;
      for (int i = 0; i < budget && bd_count == b0; i++) step();
      repeat (3) step();
      chk(tag, bd_count - b0, 1);
   endtask

   initial begin
      int b0;
      bit found;
      for (int i = 0; i < 16; i++) begin
         lbl_mem[i] = '0; pred_mem[i] = '0; never[i] = 0;
      end
      repeat (3) step();
      chk("reset_ctrl", 32'({fnn_start, label_rd, busy, batch_done, timeout_err}), 0);
      chk("reset_counts", 32'({processed_cnt, correct_cnt}), 0);
      chk("reset_idx", 32'({sample_idx, label_addr}), 0);
      rst = 1'b1;
      step();

      // Three samples, middle one mispredicted.
      lbl_mem[0] = 5; lbl_mem[1] = 2; lbl_mem[2] = 7;
      pred_mem[0] = 5; pred_mem[1] = 3; pred_mem[2] = 7;
      sb.push_back(mk(3, 2, 0));
      exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(2);
      launch(3);
      wait_bd("t1_one_batch_done", 300);
      chk("t1_done_latency", bd_cyc - last_done_cyc, 1);

      // Empty batch.
      busy_seen = 0;
      sb.push_back(mk(0, 0, 0));
      launch(0);
      repeat (3) step();
      chk("t2_busy_never", 32'(busy_seen), 0);

      // Sample 0 never answers and times out.
      lbl_mem[0] = 9; lbl_mem[1] = 4; pred_mem[0] = 0; pred_mem[1] = 4; never[0] = 1;
      sb.push_back(mk(2, 1, 1));
      exp_idx.push_back(0); exp_idx.push_back(1);
      launch(2);
      repeat (33) step();
      chk("t3_timeout_before", 32'(timeout_err), 0);
      step();
      chk("t3_timeout_after", 32'(timeout_err), 1);
      chk("t3_next_launch", 32'(fnn_start), 1);
      wait_bd("t3_one_batch_done", 300);
      never[0] = 0;

      // Abort coinciding with fnn_done of sample 2.
      lbl_mem[0] = 1; lbl_mem[1] = 2; lbl_mem[2] = 3; lbl_mem[3] = 4;
      pred_mem[0] = 1; pred_mem[1] = 0; pred_mem[2] = 3; pred_mem[3] = 4;
      sb.push_back(mk(2, 1, 0));
      exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(2);
      launch(4);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (fnn_done && sample_idx == IDX_W'(2)) found = 1;
         else step();
      end
      chk("t4_reached_sample2_done", 32'(found), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_abort_batch_done", 32'(batch_done), 1);
      chk("t4_abort_processed", 32'(processed_cnt), 2);
      repeat (25) step();
      chk("t4_idle_after_abort", 32'(busy), 0);

      // Start pulses while busy and in FINISH are ignored.
      lbl_mem[0] = 3; lbl_mem[1] = 3; pred_mem[0] = 3; pred_mem[1] = 3;
      sb.push_back(mk(2, 2, 0));
      exp_idx.push_back(0); exp_idx.push_back(1);
      launch(2);
      repeat (5) step();
      num_samples = IDX_W'(5);
      start = 1'b1;
      step();
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (batch_done) found = 1;
         else step();
      end
      chk("t5_reached_finish", 32'(found), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_finish_start_ignored", 32'({busy, fnn_start}), 0);
      chk("t5_counts_hold", 32'(processed_cnt), 2);
      step();
      chk("t5_no_late_launch", 32'(fnn_start), 0);
      sb.push_back(mk(1, 1, 0));
      exp_idx.push_back(0);
      launch(1);
      chk("t5_counts_cleared", 32'({processed_cnt, correct_cnt}), 0);
      wait_bd("t5_new_batch_done", 300);

      // Asynchronous reset in WAIT, then a fresh one-sample batch.
      lbl_mem[0] = 6; pred_mem[0] = 6;
      exp_idx.push_back(0);
      launch(2);
      repeat (5) step();
      chk("t6_in_wait_busy", 32'(busy), 1);
      b0 = bd_count;
      #2 rst = 1'b0;
      #1;
      chk("t6_async_ctrl", 32'({fnn_start, label_rd, busy, batch_done, timeout_err}), 0);
      chk("t6_async_data", 32'({sample_idx, processed_cnt, correct_cnt}), 0);
      repeat (3) step();
      chk("t6_no_batch_done", bd_count - b0, 0);
      rst = 1'b1;
      step();
      sb.push_back(mk(1, 1, 0));
      exp_idx.push_back(0);
      launch(1);
      wait_bd("t6_fresh_batch_done", 300);

      chk("sb_drained", sb.size(), 0);
      chk("launches_drained", exp_idx.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
